// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// ALU operations, register-destination and PC-source selects, decode record.
package cu_pkg;

    localparam int unsigned OPC_W   = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPC_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPC_W-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OPC_W-1:0] OP_AND   = 6'b010000;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPC_W-1:0] OP_XORI  = 6'b010011;
    localparam logic [OPC_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'b100110;
    localparam logic [OPC_W-1:0] OP_SLT   = 6'b100111;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'b110101;
    localparam logic [OPC_W-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OPC_W-1:0] OP_J     = 6'b111000;
    localparam logic [OPC_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'b111010;
    localparam logic [OPC_W-1:0] OP_HALT  = 6'b111111;

    typedef enum logic [STATE_W-1:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_BR = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_AL  = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_SLTU = 3'b010,
        ALU_SLT  = 3'b011,
        ALU_SLL  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_AND  = 3'b110,
        ALU_XOR  = 3'b111
    } aluop_e;

    localparam logic [1:0] RD_R31 = 2'b00;
    localparam logic [1:0] RD_RT  = 2'b01;
    localparam logic [1:0] RD_RD  = 2'b10;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    // Opcode class plus the ALU controls an ALU-class instruction needs
    typedef struct packed {
        logic   legal;
        logic   is_rtype;
        logic   is_imm;
        logic   is_branch;
        logic   is_mem;
        logic   is_jump;
        logic   is_halt;
        aluop_e alu_op;
        logic   alu_sa;
        logic   zero_ext;
    } dec_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode-class decode for control_unit.
// halt is only a legal opcode when CU_HALT_EN is defined.
module cu_decode
    import cu_pkg::*;
(
    input  logic [OPC_W-1:0] op,
    output dec_t             dec
);

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        case (op)
            OP_ADD:   begin dec.legal = 1'b1; dec.is_rtype = 1'b1; end
            OP_SUB:   begin dec.legal = 1'b1; dec.is_rtype = 1'b1; dec.alu_op = ALU_SUB; end
            OP_ADDIU: begin dec.legal = 1'b1; dec.is_imm = 1'b1; end
            OP_AND:   begin dec.legal = 1'b1; dec.is_rtype = 1'b1; dec.alu_op = ALU_AND; end
            OP_ANDI:  begin
                dec.legal = 1'b1; dec.is_imm = 1'b1; dec.alu_op = ALU_AND; dec.zero_ext = 1'b1;
            end
            OP_ORI:   begin
                dec.legal = 1'b1; dec.is_imm = 1'b1; dec.alu_op = ALU_OR; dec.zero_ext = 1'b1;
            end
            OP_XORI:  begin
                dec.legal = 1'b1; dec.is_imm = 1'b1; dec.alu_op = ALU_XOR; dec.zero_ext = 1'b1;
            end
            OP_SLL:   begin
                dec.legal = 1'b1; dec.is_rtype = 1'b1; dec.alu_op = ALU_SLL; dec.alu_sa = 1'b1;
            end
            OP_SLTI:  begin dec.legal = 1'b1; dec.is_imm = 1'b1; dec.alu_op = ALU_SLT; end
            OP_SLT:   begin dec.legal = 1'b1; dec.is_rtype = 1'b1; dec.alu_op = ALU_SLT; end
            OP_SW, OP_LW: begin dec.legal = 1'b1; dec.is_mem = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLTZ: begin dec.legal = 1'b1; dec.is_branch = 1'b1; end
            OP_J, OP_JR, OP_JAL: begin dec.legal = 1'b1; dec.is_jump = 1'b1; end
`ifdef CU_HALT_EN
            OP_HALT:  begin dec.legal = 1'b1; dec.is_halt = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: state register plus Moore/opcode output decode.
// Optional halt support is enabled by defining CU_HALT_EN.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned OP_W = 6,
    parameter int unsigned ST_W = 4
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            sign,
    output logic            PCWre,
    output logic            IRWre,
    output logic            InsMemRW,
    output logic            RegWre,
    output logic            mRD,
    output logic            mWR,
    output logic            ALUSrcA,
    output logic            ALUSrcB,
    output logic            ExtSel,
    output logic            WrRegDSrc,
    output logic            DBDataSrc,
    output logic [2:0]      ALUOp,
    output logic [1:0]      RegDst,
    output logic [1:0]      PCSrc,
    output logic [ST_W-1:0] state
);

    logic [OPC_W-1:0] op;
    dec_t             dec;
    state_e           cur;
    logic             running;
    logic             active;
    logic             taken;

    assign op = OPC_W'(opcode);

    cu_decode u_decode (
        .op  (op),
        .dec (dec)
    );

    assign taken = ((op == OP_BEQ) &&  zero) ||
                   ((op == OP_BNE) && !zero) ||
                   ((op == OP_BLTZ) && sign);

    // running holds off the first IF until an edge has sampled Reset high
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            cur     <= S_IF;
            running <= 1'b0;
        end else if (!running) begin
            running <= 1'b1;
        end else begin
            case (cur)
                S_IF: cur <= S_ID;
                S_ID: begin
                    if (dec.is_halt)                        cur <= S_HALT;
                    else if (dec.is_jump || !dec.legal)     cur <= S_IF;
                    else if (dec.is_branch)                 cur <= S_EXE_BR;
                    else if (dec.is_mem)                    cur <= S_EXE_LS;
                    else                                    cur <= S_EXE_AL;
                end
                S_EXE_AL: cur <= S_WB_AL;
                S_EXE_BR: cur <= S_IF;
                S_EXE_LS: cur <= S_MEM;
                S_MEM:    cur <= (op == OP_LW) ? S_WB_LD : S_IF;
                S_WB_AL:  cur <= S_IF;
                S_WB_LD:  cur <= S_IF;
                S_HALT:   cur <= S_HALT;
                default:  cur <= S_IF;
            endcase
        end
    end

    // Outputs are forced low whenever Reset is low, even before the edge
    assign active = Reset && running;

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        ALUOp     = ALU_ADD;
        RegDst    = RD_R31;
        PCSrc     = PC_SEQ;
        state     = '0;
        if (active) begin
            state = ST_W'(cur);
            case (cur)
                S_IF: begin
                    InsMemRW = 1'b1;
                    IRWre    = 1'b1;
                end
                S_ID: begin
                    if (dec.is_jump) begin
                        PCWre = 1'b1;
                        PCSrc = (op == OP_JR) ? PC_JR : PC_JMP;
                        if (op == OP_JAL) begin
                            RegWre    = 1'b1;
                            RegDst    = RD_R31;
                            WrRegDSrc = 1'b0;
                        end
                    end else if (!dec.legal) begin
                        PCWre = 1'b1;
                    end
                end
                S_EXE_AL, S_WB_AL: begin
                    ALUOp   = dec.alu_op;
                    ALUSrcA = dec.alu_sa;
                    ALUSrcB = dec.is_imm;
                    ExtSel  = ~dec.zero_ext;
                    if (cur == S_WB_AL) begin
                        RegWre    = 1'b1;
                        WrRegDSrc = 1'b1;
                        PCWre     = 1'b1;
                        RegDst    = dec.is_rtype ? RD_RD : RD_RT;
                    end
                end
                S_EXE_BR: begin
                    ALUOp  = ALU_SUB;
                    ExtSel = 1'b1;
                    PCWre  = 1'b1;
                    PCSrc  = taken ? PC_BR : PC_SEQ;
                end
                // Address computation stays stable across the whole memory access
                S_EXE_LS, S_MEM, S_WB_LD: begin
                    ALUOp   = ALU_ADD;
                    ALUSrcB = 1'b1;
                    ExtSel  = 1'b1;
                    if (cur == S_MEM) begin
                        if (op == OP_LW) begin
                            mRD = 1'b1;
                        end else begin
                            mWR   = 1'b1;
                            PCWre = 1'b1;
                        end
                    end
                    if (cur == S_WB_LD) begin
                        mRD       = 1'b1;
                        DBDataSrc = 1'b1;
                        WrRegDSrc = 1'b1;
                        RegDst    = RD_RT;
                        RegWre    = 1'b1;
                        PCWre     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, reset/halt
// sequences, and randomized instructions against an instruction-level model.
`timescale 1ns/1ps
module tb_control_unit;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic PCWre, IRWre, InsMemRW, RegWre, mRD, mWR;
    logic ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc, DBDataSrc;
    logic [2:0] ALUOp;
    logic [1:0] RegDst, PCSrc;
    logic [3:0] state;

    control_unit #(.OP_W(6), .ST_W(4)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
        .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtSel(ExtSel), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .ALUOp(ALUOp), .RegDst(RegDst), .PCSrc(PCSrc), .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic pcwre, irwre, imem, regwre, mrd, mwr;
        logic srca, srcb, ext, wrsrc, dbsrc;
        logic [2:0] aluop;
        logic [1:0] regdst, pcsrc;
        logic [3:0] st;
    } outs_t;

    outs_t act;
    assign act = {PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
                  ExtSel, WrRegDSrc, DBDataSrc, ALUOp, RegDst, PCSrc, state};

    int checks = 0;
    int errors = 0;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4;
    localparam int K_J = 5, K_JR = 6, K_JAL = 7, K_ILL = 8, K_HALT = 9;

    task automatic check_outs(input string name, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b010000, 6'b011000, 6'b100111: return K_R;
            6'b000010, 6'b010001, 6'b010010, 6'b010011, 6'b100110: return K_I;
            6'b110001: return K_LW;
            6'b110000: return K_SW;
            6'b110100, 6'b110101, 6'b110110: return K_BR;
            6'b111000: return K_J;
            6'b111001: return K_JR;
            6'b111010: return K_JAL;
`ifdef CU_HALT_EN
            6'b111111: return K_HALT;
`endif
            default: return K_ILL;
        endcase
    endfunction

    function automatic int instr_len(input int k);
        case (k)
            K_R, K_I, K_SW: return 4;
            K_LW:           return 5;
            K_BR:           return 3;
            default:        return 2;
        endcase
    endfunction

    // Expected outputs for cycle 'step' (0 = fetch) of instruction 'op'
    function automatic outs_t model(input logic [5:0] op, input int step,
                                    input logic z, input logic s);
        outs_t o;
        int k;
        logic [2:0] aop;
        o = '0;
        k = kind_of(op);
        if (step == 0) begin
            o.irwre = 1'b1; o.imem = 1'b1; o.st = 4'd0;
            return o;
        end
        if (step == 1) begin
            o.st = 4'd1;
            case (k)
                K_J:   begin o.pcwre = 1'b1; o.pcsrc = 2'b11; end
                K_JR:  begin o.pcwre = 1'b1; o.pcsrc = 2'b10; end
                K_JAL: begin o.pcwre = 1'b1; o.pcsrc = 2'b11; o.regwre = 1'b1; end
                K_ILL: o.pcwre = 1'b1;
                default: ;
            endcase
            return o;
        end
        if (k == K_HALT) begin
            o.st = 4'd8;
            return o;
        end
        case (op)
            6'b000001:            aop = 3'b001;
            6'b010000, 6'b010001: aop = 3'b110;
            6'b010010:            aop = 3'b101;
            6'b010011:            aop = 3'b111;
            6'b011000:            aop = 3'b100;
            6'b100110, 6'b100111: aop = 3'b011;
            default:              aop = 3'b000;
        endcase
        o.pcwre = (step == instr_len(k) - 1);
        if (k == K_BR) begin
            o.st = 4'd3; o.aluop = 3'b001; o.ext = 1'b1;
            if ((op == 6'b110100 && z) || (op == 6'b110101 && !z) || (op == 6'b110110 && s))
                o.pcsrc = 2'b01;
        end else if (k == K_R || k == K_I) begin
            o.st    = (step == 2) ? 4'd2 : 4'd6;
            o.aluop = aop;
            o.srca  = (op == 6'b011000);
            o.srcb  = (k == K_I);
            o.ext   = !(op == 6'b010001 || op == 6'b010010 || op == 6'b010011);
            if (step == 3) begin
                o.regwre = 1'b1; o.wrsrc = 1'b1;
                o.regdst = (k == K_R) ? 2'b10 : 2'b01;
            end
        end else begin
            o.srcb = 1'b1; o.ext = 1'b1;
            o.st   = (step == 2) ? 4'd4 : (step == 3) ? 4'd5 : 4'd7;
            if (step == 3) begin
                if (k == K_SW) o.mwr = 1'b1;
                else           o.mrd = 1'b1;
            end
            if (step == 4) begin
                o.mrd = 1'b1; o.dbsrc = 1'b1; o.wrsrc = 1'b1;
                o.regdst = 2'b01; o.regwre = 1'b1;
            end
        end
        return o;
    endfunction

    // Run 'n' cycles of instruction op from IF, checking every cycle
    task automatic run_steps(input logic [5:0] op, input int n, input string tag);
        logic z, s;
        for (int st = 0; st < n; st++) begin
            z = 1'($urandom);
            s = 1'($urandom);
            opcode = (st == 0) ? 6'($urandom) : op;
            zero = z;
            sign = s;
            #1;
            check_outs($sformatf("%s op=%b step%0d", tag, op, st), model(op, st, z, s));
            @(posedge CLK); #1;
        end
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check_outs($sformatf("reset cycle %0d", i), '0);
            @(posedge CLK); #1;
        end
        Reset = 1'b1;
        #1;
        check_outs("release idle", '0);
        @(posedge CLK); #1;
    endtask

    typedef struct {
        logic [5:0] op;
        logic       z, s;
        int         len;
        int         pcsrc, regdst, regwre, st;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] op, input logic z, input logic s,
                                input int len, input int pcsrc, input int regdst,
                                input int regwre, input int st);
        vec_t v;
        v.op = op; v.z = z; v.s = s; v.len = len;
        v.pcsrc = pcsrc; v.regdst = regdst; v.regwre = regwre; v.st = st;
        return v;
    endfunction

    vec_t tbl[14];
    logic [5:0] legal_ops[19];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200us");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(6'b000000, 0, 0, 4, 0, 2, 1, 6); // add
        tbl[1]  = mk(6'b110001, 0, 0, 5, 0, 1, 1, 7); // lw
        tbl[2]  = mk(6'b110000, 0, 0, 4, 0, 0, 0, 5); // sw
        tbl[3]  = mk(6'b110100, 1, 0, 3, 1, 0, 0, 3); // beq taken
        tbl[4]  = mk(6'b110100, 0, 1, 3, 0, 0, 0, 3); // beq not taken
        tbl[5]  = mk(6'b110101, 1, 0, 3, 0, 0, 0, 3); // bne not taken
        tbl[6]  = mk(6'b110101, 0, 0, 3, 1, 0, 0, 3); // bne taken
        tbl[7]  = mk(6'b110110, 0, 1, 3, 1, 0, 0, 3); // bltz taken
        tbl[8]  = mk(6'b110110, 1, 0, 3, 0, 0, 0, 3); // bltz not taken
        tbl[9]  = mk(6'b111010, 0, 0, 2, 3, 0, 1, 1); // jal
        tbl[10] = mk(6'b111001, 0, 0, 2, 2, 0, 0, 1); // jr
        tbl[11] = mk(6'b111000, 0, 0, 2, 3, 0, 0, 1); // j
        tbl[12] = mk(6'b010010, 0, 0, 4, 0, 1, 1, 6); // ori
        tbl[13] = mk(6'b101010, 0, 0, 2, 0, 0, 0, 1); // illegal
        legal_ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                      6'b010010, 6'b010011, 6'b011000, 6'b100110, 6'b100111,
                      6'b110000, 6'b110001, 6'b110100, 6'b110101, 6'b110110,
                      6'b111000, 6'b111001, 6'b111010, 6'b111111};

        Reset = 1'b0;
        @(posedge CLK); #1;
        do_reset(3);

        // Directed table: cycle count to PCWre and final-cycle controls
        for (int i = 0; i < 14; i++) begin
            int  cnt;
            bit  done;
            cnt  = 0;
            done = 1'b0;
            while (!done && cnt < 8) begin
                opcode = tbl[i].op;
                zero   = tbl[i].z;
                sign   = tbl[i].s;
                #1;
                cnt++;
                if (PCWre) begin
                    done = 1'b1;
                    check_val($sformatf("tbl%0d len", i), cnt, tbl[i].len);
                    check_val($sformatf("tbl%0d PCSrc", i), int'(PCSrc), tbl[i].pcsrc);
                    check_val($sformatf("tbl%0d RegDst", i), int'(RegDst), tbl[i].regdst);
                    check_val($sformatf("tbl%0d RegWre", i), int'(RegWre), tbl[i].regwre);
                    check_val($sformatf("tbl%0d state", i), int'(state), tbl[i].st);
                end
                @(posedge CLK); #1;
            end
            if (!done) check_val($sformatf("tbl%0d PCWre timeout", i), cnt, tbl[i].len);
            check_val($sformatf("tbl%0d back to IF", i), int'(state), 0);
        end

        // Reset held 3 cycles in the middle of WB_LD
        run_steps(6'b110001, 4, "lw pre-reset");
        opcode = 6'b110001; #1;
        check_val("lw at WB_LD state", int'(state), 7);
        do_reset(3);
        run_steps(6'b000000, 4, "add after reset");

        // halt handling
        run_steps(6'b111111, 2, "halt");
`ifdef CU_HALT_EN
        for (int i = 0; i < 20; i++) begin
            opcode = 6'($urandom); #1;
            check_outs($sformatf("halt hold %0d", i), model(6'b111111, 2, 1'b0, 1'b0));
            @(posedge CLK); #1;
        end
        do_reset(2);
`else
        #1;
        check_val("halt-as-illegal returns to IF", int'(state), 0);
`endif

        // Randomized instruction stream against the model
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else                           op = legal_ops[$urandom_range(0, 18)];
`ifdef CU_HALT_EN
            if (op == 6'b111111) op = 6'b101010;
`endif
            run_steps(op, instr_len(kind_of(op)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
